// File: rtl/ahbl_pkg.sv
// Shared AHB-lite encodings: transfer types, response codes, transfer sizes.
package ahbl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011
  } hsize_e;

  // Width of the non-address address-phase controls:
  // hwrite(1) + htrans(2) + hsize(3) + hburst(3) + hprot(4) + hmastlock(1).
  localparam int AP_CTRL_W = 14;

  // NONSEQ and SEQ both have htrans[1] set; IDLE and BUSY do not.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahbl_arbiter_prio.sv
// One-hot priority selector. Search starts at index 'base' and wraps around;
// tie base to zero for plain lowest-index-wins priority.
module ahbl_arbiter_prio
  import ahbl_pkg::*;
#(
  parameter int N     = 2,
  parameter int W_IDX = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [W_IDX-1:0] base,
  output logic [N-1:0]     gnt
);

  localparam int SUM_W = W_IDX + 1;

  logic             found;
  logic [SUM_W-1:0] sum;
  logic [W_IDX-1:0] idx;

  // Walk the requesters starting from base and grant the first one found.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, base} + SUM_W'(k);
      if (sum >= SUM_W'(N)) begin
        sum = sum - SUM_W'(N);
      end
      idx = sum[W_IDX-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onehot_mux.sv
// Generic AND-OR multiplexer driven by a one-hot (or all-zero) select.
// An all-zero select yields an all-zero output.
module onehot_mux #(
  parameter int N = 2,
  parameter int W = 32
) (
  input  logic [N-1:0]   sel,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   dout
);

  // OR together every input lane that is enabled by its select bit.
  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++) begin
      dout = dout | (din[i*W +: W] & {W{sel[i]}});
    end
  end

endmodule

// File: rtl/ahbl_arbiter.sv
// AHB-lite N:1 arbiter. Losing address phases are parked in a per-master
// buffer and replayed downstream; the losing master is stalled in its data
// phase until the replayed transfer completes.
// Optional build macro AHBL_ARBITER_ROUND_ROBIN_EN: rotating priority that
// starts one past the last committed master. Undefined: lowest index wins.
module ahbl_arbiter
  import ahbl_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_PORTS-1:0]         src_hready,
  output logic [N_PORTS-1:0]         src_hready_resp,
  output logic [N_PORTS-1:0]         src_hresp,
  input  logic [N_PORTS*W_ADDR-1:0]  src_haddr,
  input  logic [N_PORTS-1:0]         src_hwrite,
  input  logic [N_PORTS*2-1:0]       src_htrans,
  input  logic [N_PORTS*3-1:0]       src_hsize,
  input  logic [N_PORTS*3-1:0]       src_hburst,
  input  logic [N_PORTS*4-1:0]       src_hprot,
  input  logic [N_PORTS-1:0]         src_hmastlock,
  input  logic [N_PORTS*W_DATA-1:0]  src_hwdata,
  output logic [N_PORTS*W_DATA-1:0]  src_hrdata,
  output logic                       dst_hready,
  input  logic                       dst_hready_resp,
  input  logic                       dst_hresp,
  output logic [W_ADDR-1:0]          dst_haddr,
  output logic                       dst_hwrite,
  output logic [1:0]                 dst_htrans,
  output logic [2:0]                 dst_hsize,
  output logic [2:0]                 dst_hburst,
  output logic [3:0]                 dst_hprot,
  output logic                       dst_hmastlock,
  output logic [W_DATA-1:0]          dst_hwdata,
  input  logic [W_DATA-1:0]          dst_hrdata
);

  localparam int W_AP  = W_ADDR + AP_CTRL_W;
  localparam int W_IDX = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [N_PORTS-1:0]      buf_valid;
  logic [N_PORTS-1:0]      gnt_d;
  logic [N_PORTS-1:0]      gnt_a;
  logic [N_PORTS-1:0]      req;
  logic [N_PORTS-1:0]      live_req;
  logic [N_PORTS-1:0]      commit;
  logic [W_AP-1:0]         buf_ap [N_PORTS];
  logic [N_PORTS*W_AP-1:0] live_ap;
  logic [N_PORTS*W_AP-1:0] cand_ap;
  logic [W_AP-1:0]         dst_ap;
  logic [W_IDX-1:0]        prio_base;

  // Pack each master's address phase and pick buffered or live as its candidate.
  always_comb begin
    live_ap  = '0;
    cand_ap  = '0;
    live_req = '0;
    req      = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      live_ap[i*W_AP +: W_AP] = {src_haddr[i*W_ADDR +: W_ADDR], src_hwrite[i],
                                 src_htrans[i*2 +: 2], src_hsize[i*3 +: 3],
                                 src_hburst[i*3 +: 3], src_hprot[i*4 +: 4],
                                 src_hmastlock[i]};
      live_req[i] = !buf_valid[i] && src_hready[i] && htrans_active(src_htrans[i*2 +: 2]);
      req[i]      = buf_valid[i] || live_req[i];
      cand_ap[i*W_AP +: W_AP] = buf_valid[i] ? buf_ap[i] : live_ap[i*W_AP +: W_AP];
    end
  end

  ahbl_arbiter_prio #(
    .N     (N_PORTS),
    .W_IDX (W_IDX)
  ) u_prio (
    .req  (req),
    .base (prio_base),
    .gnt  (gnt_a)
  );

  assign commit = gnt_a & {N_PORTS{dst_hready_resp}};

`ifdef AHBL_ARBITER_ROUND_ROBIN_EN
  logic [W_IDX-1:0] rr_ptr;
  logic [W_IDX-1:0] rr_next;

  // Next search base is one past whichever master commits this cycle.
  always_comb begin
    rr_next = rr_ptr;
    for (int i = 0; i < N_PORTS; i++) begin
      if (commit[i]) begin
        rr_next = (i == N_PORTS - 1) ? '0 : W_IDX'(i + 1);
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= rr_next;
    end
  end

  assign prio_base = rr_ptr;
`else
  assign prio_base = '0;
`endif

  // Data-phase owner follows the granted master whenever the slave is ready;
  // a live request that fails to commit is parked, a committed one is released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_d     <= '0;
      buf_valid <= '0;
    end else begin
      if (dst_hready_resp) begin
        gnt_d <= gnt_a;
      end
      for (int i = 0; i < N_PORTS; i++) begin
        if (commit[i]) begin
          buf_valid[i] <= 1'b0;
        end else if (live_req[i]) begin
          buf_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Buffer payload needs no reset; it is only read while buf_valid is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_PORTS; i++) begin
      if (live_req[i] && !commit[i]) begin
        buf_ap[i] <= live_ap[i*W_AP +: W_AP];
      end
    end
  end

  onehot_mux #(
    .N (N_PORTS),
    .W (W_AP)
  ) u_ap_mux (
    .sel  (gnt_a),
    .din  (cand_ap),
    .dout (dst_ap)
  );

  assign {dst_haddr, dst_hwrite, dst_htrans, dst_hsize,
          dst_hburst, dst_hprot, dst_hmastlock} = dst_ap;

  onehot_mux #(
    .N (N_PORTS),
    .W (W_DATA)
  ) u_wdata_mux (
    .sel  (gnt_d),
    .din  (src_hwdata),
    .dout (dst_hwdata)
  );

  // Data-phase owner sees the slave's ready/response; a parked master is stalled.
  always_comb begin
    src_hready_resp = '0;
    src_hresp       = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      src_hready_resp[i] = gnt_d[i] ? dst_hready_resp : !buf_valid[i];
      src_hresp[i]       = gnt_d[i] & dst_hresp;
    end
  end

  assign dst_hready = dst_hready_resp;
  assign src_hrdata = {N_PORTS{dst_hrdata}};

endmodule

// File: tb/tb_ahbl_arbiter.sv
// Directed, table-driven bench for ahbl_arbiter with two masters.
module tb_ahbl_arbiter;
  import ahbl_pkg::*;

  localparam int NP = 2;
  localparam int NV = 17;
`ifdef AHBL_ARBITER_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [NP-1:0]    src_hready;
  logic [NP-1:0]    src_hready_resp;
  logic [NP-1:0]    src_hresp;
  logic [NP*32-1:0] src_haddr;
  logic [NP-1:0]    src_hwrite;
  logic [NP*2-1:0]  src_htrans;
  logic [NP*3-1:0]  src_hsize;
  logic [NP*3-1:0]  src_hburst;
  logic [NP*4-1:0]  src_hprot;
  logic [NP-1:0]    src_hmastlock;
  logic [NP*32-1:0] src_hwdata;
  logic [NP*32-1:0] src_hrdata;
  logic             dst_hready;
  logic             dst_hready_resp;
  logic             dst_hresp;
  logic [31:0]      dst_haddr;
  logic             dst_hwrite;
  logic [1:0]       dst_htrans;
  logic [2:0]       dst_hsize;
  logic [2:0]       dst_hburst;
  logic [3:0]       dst_hprot;
  logic             dst_hmastlock;
  logic [31:0]      dst_hwdata;
  logic [31:0]      dst_hrdata;

  int nTests = 0;
  int nFails = 0;

  typedef struct {
    logic        rst_n;
    logic [1:0]  t0;
    logic [31:0] a0;
    logic        w0;
    logic [31:0] d0;
    logic [1:0]  t1;
    logic [31:0] a1;
    logic        w1;
    logic [31:0] d1;
    logic        rdy;
    logic        resp;
    logic [31:0] rdata;
    logic [1:0]  eHrr;
    logic [1:0]  eHresp;
    logic [1:0]  eTrans;
    logic        chkAddr;
    logic [31:0] eAddr;
    logic        eWrite;
    logic        chkWdata;
    logic [31:0] eWdata;
  } vec_t;

  vec_t vecs [NV];

  ahbl_arbiter #(
    .N_PORTS (NP),
    .W_ADDR  (32),
    .W_DATA  (32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .src_hready      (src_hready),
    .src_hready_resp (src_hready_resp),
    .src_hresp       (src_hresp),
    .src_haddr       (src_haddr),
    .src_hwrite      (src_hwrite),
    .src_htrans      (src_htrans),
    .src_hsize       (src_hsize),
    .src_hburst      (src_hburst),
    .src_hprot       (src_hprot),
    .src_hmastlock   (src_hmastlock),
    .src_hwdata      (src_hwdata),
    .src_hrdata      (src_hrdata),
    .dst_hready      (dst_hready),
    .dst_hready_resp (dst_hready_resp),
    .dst_hresp       (dst_hresp),
    .dst_haddr       (dst_haddr),
    .dst_hwrite      (dst_hwrite),
    .dst_htrans      (dst_htrans),
    .dst_hsize       (dst_hsize),
    .dst_hburst      (dst_hburst),
    .dst_hprot       (dst_hprot),
    .dst_hmastlock   (dst_hmastlock),
    .dst_hwdata      (dst_hwdata),
    .dst_hrdata      (dst_hrdata)
  );

  // Each master sees its own HREADYOUT as its global HREADY.
  assign src_hready = src_hready_resp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(
    input logic rst, input logic [1:0] t0, input logic [31:0] a0, input logic w0, input logic [31:0] d0,
    input logic [1:0] t1, input logic [31:0] a1, input logic w1, input logic [31:0] d1,
    input logic rdy, input logic resp, input logic [31:0] rdata,
    input logic [1:0] eHrr, input logic [1:0] eHresp, input logic [1:0] eTrans,
    input logic chkAddr, input logic [31:0] eAddr, input logic eWrite,
    input logic chkWdata, input logic [31:0] eWdata);
    vec_t v;
    v.rst_n = rst; v.t0 = t0; v.a0 = a0; v.w0 = w0; v.d0 = d0;
    v.t1 = t1; v.a1 = a1; v.w1 = w1; v.d1 = d1;
    v.rdy = rdy; v.resp = resp; v.rdata = rdata;
    v.eHrr = eHrr; v.eHresp = eHresp; v.eTrans = eTrans;
    v.chkAddr = chkAddr; v.eAddr = eAddr; v.eWrite = eWrite;
    v.chkWdata = chkWdata; v.eWdata = eWdata;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst_n           = v.rst_n;
    src_htrans      = {v.t1, v.t0};
    src_haddr       = {v.a1, v.a0};
    src_hwrite      = {v.w1, v.w0};
    src_hwdata      = {v.d1, v.d0};
    src_hsize       = {3'(HSIZE_WORD), 3'(HSIZE_WORD)};
    src_hburst      = '0;
    src_hprot       = {4'b0011, 4'b0011};
    src_hmastlock   = '0;
    dst_hready_resp = v.rdy;
    dst_hresp       = v.resp;
    dst_hrdata      = v.rdata;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  localparam logic [1:0] I = HTRANS_IDLE;
  localparam logic [1:0] N = HTRANS_NONSEQ;

  initial begin
    // single master read, zero wait
    vecs[0]  = mkVec(1, I, 0, 0, 0,            I, 0, 0, 0,            1, 0, 0,            2'b11, 2'b00, I, 0, 0, 0, 0, 0);
    vecs[1]  = mkVec(1, N, 32'h100, 0, 0,      I, 0, 0, 0,            1, 0, 0,            2'b11, 2'b00, N, 1, 32'h100, 0, 0, 0);
    vecs[2]  = mkVec(0, I, 0, 0, 0,            I, 0, 0, 0,            1, 0, 32'hdeadbeef, 2'b11, 2'b00, I, 0, 0, 0, 0, 0);
    // collision: m0 wins, m1 replayed from buffer next cycle
    vecs[3]  = mkVec(1, N, 32'h10, 1, 0,       N, 32'h20, 1, 0,       1, 0, 0,            2'b11, 2'b00, N, 1, 32'h10, 1, 0, 0);
    vecs[4]  = mkVec(1, I, 0, 0, 32'h11111111, I, 0, 0, 32'h22222222, 1, 0, 0,            2'b01, 2'b00, N, 1, 32'h20, 1, 1, 32'h11111111);
    vecs[5]  = mkVec(1, I, 0, 0, 0,            I, 0, 0, 32'h22222222, 1, 0, 0,            2'b11, 2'b00, I, 0, 0, 0, 1, 32'h22222222);
    // wait states on m0's data phase while m1 requests
    vecs[6]  = mkVec(1, N, 32'h10, 0, 0,       I, 0, 0, 0,            1, 0, 0,            2'b11, 2'b00, N, 1, 32'h10, 0, 0, 0);
    vecs[7]  = mkVec(1, I, 0, 0, 0,            N, 32'h20, 0, 0,       0, 0, 0,            2'b10, 2'b00, N, 1, 32'h20, 0, 0, 0);
    vecs[8]  = mkVec(1, I, 0, 0, 0,            I, 0, 0, 0,            0, 0, 0,            2'b00, 2'b00, N, 1, 32'h20, 0, 0, 0);
    vecs[9]  = mkVec(1, I, 0, 0, 0,            I, 0, 0, 0,            0, 0, 0,            2'b00, 2'b00, N, 1, 32'h20, 0, 0, 0);
    vecs[10] = mkVec(1, I, 0, 0, 0,            I, 0, 0, 0,            1, 0, 32'hcafef00d, 2'b01, 2'b00, N, 1, 32'h20, 0, 0, 0);
    // two-cycle ERROR to m1 while m0 gets parked and then replayed
    vecs[11] = mkVec(1, N, 32'h40, 0, 0,       I, 0, 0, 0,            0, 1, 0,            2'b01, 2'b10, N, 1, 32'h40, 0, 0, 0);
    vecs[12] = mkVec(1, I, 0, 0, 0,            I, 0, 0, 0,            1, 1, 0,            2'b10, 2'b10, N, 1, 32'h40, 0, 0, 0);
    vecs[13] = mkVec(0, I, 0, 0, 0,            I, 0, 0, 0,            1, 0, 32'h12345678, 2'b11, 2'b00, I, 0, 0, 0, 0, 0);
    // reset while m1 is parked
    vecs[14] = mkVec(1, N, 32'h50, 1, 0,       N, 32'h60, 1, 0,       1, 0, 0,            2'b11, 2'b00, N, 1, 32'h50, 1, 0, 0);
    vecs[15] = mkVec(0, I, 0, 0, 32'h55555555, I, 0, 0, 32'h66666666, 1, 0, 0,            2'b01, 2'b00, N, 1, 32'h60, 1, 1, 32'h55555555);
    vecs[16] = mkVec(1, I, 0, 0, 0,            I, 0, 0, 0,            1, 0, 0,            2'b11, 2'b00, I, 0, 0, 0, 0, 0);

    // Hold reset for two edges before the table starts.
    applyStimulus(mkVec(0, I, 0, 0, 0, I, 0, 0, 0, 1, 0, 0, 0, 0, I, 0, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput("src_hready_resp", i, 32'(src_hready_resp), 32'(vecs[i].eHrr));
      checkOutput("src_hresp", i, 32'(src_hresp), 32'(vecs[i].eHresp));
      checkOutput("dst_htrans", i, 32'(dst_htrans), 32'(vecs[i].eTrans));
      checkOutput("dst_hready", i, 32'(dst_hready), 32'(vecs[i].rdy));
      checkOutput("src_hrdata0", i, src_hrdata[31:0], vecs[i].rdata);
      checkOutput("src_hrdata1", i, src_hrdata[63:32], vecs[i].rdata);
      if (vecs[i].chkAddr) begin
        checkOutput("dst_haddr", i, dst_haddr, vecs[i].eAddr);
        checkOutput("dst_hwrite", i, 32'(dst_hwrite), 32'(vecs[i].eWrite));
        checkOutput("dst_hsize", i, 32'(dst_hsize), 32'(HSIZE_WORD));
      end
      if (vecs[i].chkWdata) begin
        checkOutput("dst_hwdata", i, dst_hwdata, vecs[i].eWdata);
      end
    end

    // Both masters request every cycle: fixed priority keeps m0, rotation alternates.
    for (int k = 0; k < 6; k++) begin
      logic [31:0] expAddr;
      @(negedge clk);
      applyStimulus(mkVec(1, N, 32'h10, 0, 0, N, 32'h20, 0, 0, 1, 0, 0, 0, 0, I, 0, 0, 0, 0, 0));
      #1;
      expAddr = (RR_EN && (k % 2 == 1)) ? 32'h20 : 32'h10;
      checkOutput("contend_haddr", 100 + k, dst_haddr, expAddr);
      checkOutput("contend_htrans", 100 + k, 32'(dst_htrans), 32'(HTRANS_NONSEQ));
      checkOutput("contend_hresp", 100 + k, 32'(src_hresp), 32'd0);
    end

    @(negedge clk);
    applyStimulus(mkVec(1, I, 0, 0, 0, I, 0, 0, 0, 1, 0, 0, 0, 0, I, 0, 0, 0, 0, 0));
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule
